// File: rtl/turf_bus_rr_arb.sv
// Round-robin arbiter sharing one en/wr/ack register slave between NMASTERS masters.
// A slave that does not ack within TIMEOUT cycles is aborted with ERR_DATA.
module turf_bus_rr_arb #(
  parameter int          NMASTERS  = 2,
  parameter int          ADDR_BITS = 28,
  parameter int          DATA_BITS = 32,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADDEAD
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NMASTERS-1:0]             s_en_i,
  input  logic [NMASTERS-1:0]             s_wr_i,
  input  logic [NMASTERS*ADDR_BITS-1:0]   s_adr_i,
  input  logic [NMASTERS*DATA_BITS-1:0]   s_dat_i,
  output logic [NMASTERS-1:0]             s_ack_o,
  output logic [NMASTERS*DATA_BITS-1:0]   s_dat_o,
  output logic                            m_en_o,
  output logic                            m_wr_o,
  output logic [ADDR_BITS-1:0]            m_adr_o,
  output logic [DATA_BITS-1:0]            m_dat_o,
  input  logic                            m_ack_i,
  input  logic [DATA_BITS-1:0]            m_dat_i,
  output logic [2:0]                      grant_o,
  output logic                            timeout_o,
  output logic [15:0]                     timeout_count_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]  PTR_RST = 3'(NMASTERS - 1);

  state_t                          state_q, state_d;
  logic [2:0]                      ptr_q, ptr_d;
  logic [2:0]                      grant_q, grant_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [15:0]                     tcnt_q, tcnt_d;
  logic                            m_en_q, m_en_d;
  logic                            m_wr_q, m_wr_d;
  logic [ADDR_BITS-1:0]            m_adr_q, m_adr_d;
  logic [DATA_BITS-1:0]            m_dat_q, m_dat_d;
  logic [NMASTERS-1:0]             s_ack_q, s_ack_d;
  logic [NMASTERS*DATA_BITS-1:0]   s_dat_q, s_dat_d;
  logic                            timeout_q, timeout_d;

  logic                            found;
  logic [2:0]                      winner;
  logic                            w_wr;
  logic [ADDR_BITS-1:0]            w_adr;
  logic [DATA_BITS-1:0]            w_dat;
  int                              best_rank;
  int                              rank;

  // Rank 0 is the master just after ptr; the lowest-ranked requester wins.
  always_comb begin
    best_rank = NMASTERS;
    rank      = 0;
    winner    = ptr_q;
    w_wr      = 1'b0;
    w_adr     = '0;
    w_dat     = '0;
    for (int j = 0; j < NMASTERS; j++) begin
      rank = (j + NMASTERS - 1 - int'(ptr_q)) % NMASTERS;
      if (s_en_i[j] && rank < best_rank) begin
        best_rank = rank;
        winner    = 3'(j);
        w_wr      = s_wr_i[j];
        w_adr     = s_adr_i[j*ADDR_BITS +: ADDR_BITS];
        w_dat     = s_dat_i[j*DATA_BITS +: DATA_BITS];
      end
    end
    found = (best_rank < NMASTERS);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    m_en_d    = m_en_q;
    m_wr_d    = m_wr_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    s_ack_d   = '0;
    s_dat_d   = s_dat_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          m_en_d  = 1'b1;
          m_wr_d  = w_wr;
          m_adr_d = w_adr;
          m_dat_d = w_dat;
          grant_d = winner;
          ptr_d   = winner;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // A real ack in the final cycle beats the abort.
        if (m_ack_i || cnt_q == TO_LAST) begin
          for (int i = 0; i < NMASTERS; i++) begin
            if (grant_q == 3'(i)) begin
              s_ack_d[i] = 1'b1;
              s_dat_d[i*DATA_BITS +: DATA_BITS] = m_ack_i ? m_dat_i : DATA_BITS'(ERR_DATA);
            end
          end
          m_en_d  = 1'b0;
          state_d = RELEASE;
          if (!m_ack_i) begin
            timeout_d = 1'b1;
            tcnt_d    = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      m_en_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      s_ack_q   <= '0;
      s_dat_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      m_en_q    <= m_en_d;
      m_wr_q    <= m_wr_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      s_ack_q   <= s_ack_d;
      s_dat_q   <= s_dat_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_ack_o         = s_ack_q;
  assign s_dat_o         = s_dat_q;
  assign m_en_o          = m_en_q;
  assign m_wr_o          = m_wr_q;
  assign m_adr_o         = m_adr_q;
  assign m_dat_o         = m_dat_q;
  assign grant_o         = grant_q;
  assign timeout_o       = timeout_q;
  assign timeout_count_o = tcnt_q;

endmodule

// File: tb/tb_turf_bus_rr_arb.sv
// Directed bench for turf_bus_rr_arb: table of transactions plus hand-written
// abort, ack-at-deadline and mid-transaction reset sequences.
module tb_turf_bus_rr_arb;
  localparam int NM = 2;
  localparam int AB = 28;
  localparam int DB = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NM-1:0]     s_en_i, s_wr_i, s_ack_o;
  logic [NM*AB-1:0]  s_adr_i;
  logic [NM*DB-1:0]  s_dat_i, s_dat_o;
  logic              m_en_o, m_wr_o, m_ack_i;
  logic [AB-1:0]     m_adr_o;
  logic [DB-1:0]     m_dat_o, m_dat_i;
  logic [2:0]        grant_o;
  logic              timeout_o;
  logic [15:0]       timeout_count_o;

  always #5 aclk = ~aclk;

  turf_bus_rr_arb dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_en_i(s_en_i), .s_wr_i(s_wr_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_dat_o(s_dat_o),
    .m_en_o(m_en_o), .m_wr_o(m_wr_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
  );

  typedef struct {
    logic [NM-1:0] req;
    logic          wr;
    logic [AB-1:0] adr;
    logic [DB-1:0] wdat;
    int            dly;
    logic [DB-1:0] rdat;
    int            exp_g;
  } vec_t;

  vec_t          vecs[6];
  logic [DB-1:0] exp_sdat[NM];
  logic [15:0]   exp_tc;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_sdat(input string name);
    check(name, 64'(s_dat_o), {exp_sdat[1], exp_sdat[0]});
  endtask

  // Master i uses adr+4*i and wdat^i, so the forwarded fields identify the winner.
  task automatic drive_req(input vec_t v);
    for (int i = 0; i < NM; i++) begin
      s_wr_i[i]             = v.wr;
      s_adr_i[i*AB +: AB]   = v.adr + AB'(i * 4);
      s_dat_i[i*DB +: DB]   = v.wdat ^ DB'(i);
    end
    s_en_i = v.req;
  endtask

  task automatic run_txn(input vec_t v);
    logic [AB-1:0] eadr;
    logic [DB-1:0] edat;
    eadr = v.adr + AB'(v.exp_g * 4);
    edat = v.wdat ^ DB'(v.exp_g);
    drive_req(v);
    @(negedge aclk);
    check("m_en_rise", 64'(m_en_o), 64'd1);
    check("grant", 64'(grant_o), 64'(v.exp_g));
    check("m_wr", 64'(m_wr_o), 64'(v.wr));
    check("m_adr", 64'(m_adr_o), 64'(eadr));
    check("m_dat", 64'(m_dat_o), 64'(edat));
    for (int c = 0; c < v.dly; c++) begin
      @(negedge aclk);
      check("m_en_held", 64'(m_en_o), 64'd1);
      check("m_stable", {3'(m_wr_o), m_adr_o, m_dat_o}, {3'(v.wr), eadr, edat});
    end
    m_ack_i = 1'b1;
    m_dat_i = v.rdat;
    @(negedge aclk);
    m_ack_i = 1'b0;
    m_dat_i = '0;
    exp_sdat[v.exp_g] = v.rdat;
    check("s_ack", 64'(s_ack_o), 64'd1 << v.exp_g);
    check_sdat("s_dat");
    check("m_en_drop", 64'(m_en_o), 64'd0);
    check("no_timeout", 64'(timeout_o), 64'd0);
    check("tcount", 64'(timeout_count_o), 64'(exp_tc));
    s_en_i = '0;
    @(negedge aclk);
    check("s_ack_clear", 64'(s_ack_o), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {4'(m_en_o), 4'(m_wr_o), 4'(s_ack_o), 4'(grant_o), 4'(timeout_o),
                 16'(timeout_count_o), 28'(m_adr_o)}, 64'd0);
    check({name, "_dat"}, {m_dat_o, 32'd0}, 64'd0);
    check({name, "_sdat"}, 64'(s_dat_o), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   en_cycles;

    vecs[0] = '{req: 2'b01, wr: 1'b0, adr: 28'h0000004, wdat: 32'h0,        dly: 2, rdat: 32'h54555246, exp_g: 0};
    vecs[1] = '{req: 2'b11, wr: 1'b0, adr: 28'h0000020, wdat: 32'h0,        dly: 1, rdat: 32'h11112222, exp_g: 1};
    vecs[2] = '{req: 2'b11, wr: 1'b0, adr: 28'h0000030, wdat: 32'h0,        dly: 0, rdat: 32'h33334444, exp_g: 0};
    vecs[3] = '{req: 2'b11, wr: 1'b1, adr: 28'h0000040, wdat: 32'h01020304, dly: 3, rdat: 32'h55556666, exp_g: 1};
    vecs[4] = '{req: 2'b10, wr: 1'b1, adr: 28'h000000C, wdat: 32'hA5A5A5A4, dly: 4, rdat: 32'h77778888, exp_g: 1};
    vecs[5] = '{req: 2'b01, wr: 1'b0, adr: 28'h0ABCDE0, wdat: 32'h0,        dly: 0, rdat: 32'h9999AAAA, exp_g: 0};

    aresetn = 1'b0;
    s_en_i  = '0;
    s_wr_i  = '0;
    s_adr_i = '0;
    s_dat_i = '0;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    exp_tc  = '0;
    for (int i = 0; i < NM; i++) exp_sdat[i] = '0;
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    // vecs[4]: master 1 at 0x0C+4 = 0x10 with 0xA5A5A5A4^1 = 0xA5A5A5A5
    for (int n = 0; n < 6; n++) run_txn(vecs[n]);

    // Stuck slave: abort after exactly 255 enable cycles
    v = '{req: 2'b01, wr: 1'b0, adr: 28'h0000100, wdat: 32'h0, dly: 0, rdat: 32'h0, exp_g: 0};
    drive_req(v);
    en_cycles = 0;
    @(negedge aclk);
    while (m_en_o && en_cycles < 400) begin
      en_cycles++;
      @(negedge aclk);
    end
    check("abort_en_cycles", 64'(en_cycles), 64'd255);
    exp_sdat[0] = 32'hDEADDEAD;
    exp_tc      = 16'd1;
    check("abort_ack", 64'(s_ack_o), 64'd1);
    check_sdat("abort_dat");
    check("abort_pulse", 64'(timeout_o), 64'd1);
    check("abort_count", 64'(timeout_count_o), 64'(exp_tc));
    s_en_i = '0;
    @(negedge aclk);
    check("abort_pulse_end", 64'(timeout_o), 64'd0);
    check("abort_ack_end", 64'(s_ack_o), 64'd0);
    @(negedge aclk);
    @(negedge aclk);
    m_ack_i = 1'b1;
    m_dat_i = 32'h12345678;
    @(negedge aclk);
    m_ack_i = 1'b0;
    m_dat_i = '0;
    for (int c = 0; c < 3; c++) begin
      check("late_ack_ignored", 64'(s_ack_o), 64'd0);
      check_sdat("late_ack_dat");
      check("late_ack_no_en", 64'(m_en_o), 64'd0);
      @(negedge aclk);
    end

    // Ack in the 255th BUSY cycle wins over the abort
    v = '{req: 2'b10, wr: 1'b0, adr: 28'h0000200, wdat: 32'h0, dly: 254, rdat: 32'hCAFEF00D, exp_g: 1};
    run_txn(v);
    check("deadline_count", 64'(timeout_count_o), 64'd1);

    // Reset in the middle of a master 0 write
    v = '{req: 2'b01, wr: 1'b1, adr: 28'h0000300, wdat: 32'hBEEF0001, dly: 0, rdat: 32'h0, exp_g: 0};
    drive_req(v);
    @(negedge aclk);
    check("pre_reset_en", 64'(m_en_o), 64'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    s_en_i = '0;
    exp_tc = '0;
    for (int i = 0; i < NM; i++) exp_sdat[i] = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    // Pointer restarts at NMASTERS-1, so master 0 wins a tie again
    v = '{req: 2'b11, wr: 1'b0, adr: 28'h0000400, wdat: 32'h0, dly: 1, rdat: 32'h0BADC0DE, exp_g: 0};
    run_txn(v);
    v = '{req: 2'b10, wr: 1'b0, adr: 28'h0000500, wdat: 32'h0, dly: 2, rdat: 32'h600DF00D, exp_g: 1};
    run_txn(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
